fetch_pc_unit: RTL and testbench

Fetch-stage PC generator and misprediction checker for the five-stage CPU. It owns the architectural fetch PC, steers it from the branch predictor's IF-stage prediction, and carries each fetched instruction's prediction metadata down to EX. In EX it compares that metadata against the resolved outcome and issues redirects and flushes. It also handles trap entry and `mret` redirects and keeps branch and mispredict performance counters.

---
 rtl/cpu_pkg.sv | 26 ++
 rtl/sat_counter.sv | 30 +++
 rtl/fetch_pc_unit.sv | 132 +++++++++++++
 tb/tb_fetch_pc_unit.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared types for the five-stage CPU front end.
// Holds branch-type encoding and per-stage fetch metadata.
package cpu_pkg;

    typedef enum logic [1:0] {
        OTHER = 2'b00,
        JAL   = 2'b01,
        BR    = 2'b10,
        JALR  = 2'b11
    } btype_e;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        p_taken;
        logic [31:0] p_target;
    } fetch_meta_t;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; sticks at all-ones.
// Cleared only by the asynchronous reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}}))
            count_d = count_q + {{(W-1){1'b0}}, 1'b1};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count_q <= '0;
        else
            count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/fetch_pc_unit.sv
// Fetch PC generator with EX-stage mispredict check,
// trap/mret redirects and branch performance counters.
module fetch_pc_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 IF_DONE,
    input  logic                 MEM_DONE,
    input  logic                 load_use_stall,
    input  logic                 trap_req,
    input  logic [31:0]          trap_vec,
    input  logic                 mret_req,
    input  logic [31:0]          mret_pc,
    input  logic                 IF_pTaken,
    input  logic [31:0]          IF_pTarget,
    input  logic [1:0]           EX_bType,
    input  logic                 EX_rTaken,
    input  logic [31:0]          EX_bTarget,
    output logic [31:0]          IF_PC,
    output logic [31:0]          ID_PC,
    output logic [31:0]          EX_PC,
    output logic                 ID_valid,
    output logic                 EX_valid,
    output logic                 flush_IFID,
    output logic                 flush_IDEX,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] mp_count
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    fetch_meta_t  id_q, id_d;
    fetch_meta_t  ex_q, ex_d;

    btype_e      ex_type;
    logic [31:0] ex_pc4;
    logic [31:0] actual_next;
    logic [31:0] pred_next;
    logic        ex_chk;
    logic        ex_taken;
    logic        redirect;
    logic        adv;
    logic        br_inc;
    logic        mp_inc;

    always_comb begin
        adv         = IF_DONE && MEM_DONE;
        ex_type     = btype_e'(EX_bType);
        ex_pc4      = ex_q.pc + 32'd4;
        ex_taken    = (ex_type == JAL) || (ex_type == JALR) ||
                      ((ex_type == BR) && EX_rTaken);
        actual_next = ex_taken ? EX_bTarget : ex_pc4;
        pred_next   = ex_q.p_taken ? ex_q.p_target : ex_pc4;
        ex_chk      = ex_q.valid && (state_q == RUN);
        mispredict  = ex_chk && (actual_next != pred_next);
        redirect    = trap_req || mret_req || mispredict;
        flush_IFID  = redirect;
        flush_IDEX  = redirect;
        br_inc      = adv && ex_chk && (ex_type != OTHER);
        mp_inc      = adv && mispredict;
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        id_d    = id_q;
        ex_d    = ex_q;
        if (adv) begin
            state_d = RUN;
            // Redirect sources are prioritised; a redirect overrides a stall.
            if (redirect) begin
                if (trap_req)
                    pc_d = trap_vec;
                else if (mret_req)
                    pc_d = mret_pc;
                else
                    pc_d = actual_next;
                id_d.valid = 1'b0;
                ex_d.valid = 1'b0;
            end else if (load_use_stall) begin
                ex_d.valid = 1'b0;
            end else begin
                pc_d = IF_pTaken ? IF_pTarget : pc_q + 32'd4;
                ex_d = id_q;
                id_d = '{valid:    1'b1,
                         pc:       pc_q,
                         p_taken:  IF_pTaken,
                         p_target: IF_pTarget};
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            id_q    <= '0;
            ex_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            id_q    <= id_d;
            ex_q    <= ex_d;
        end
    end

    assign IF_PC    = pc_q;
    assign ID_PC    = id_q.pc;
    assign EX_PC    = ex_q.pc;
    assign ID_valid = id_q.valid;
    assign EX_valid = ex_q.valid;

    sat_counter #(.W(CNT_WIDTH)) u_br_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (br_inc),
        .count (br_count)
    );

    sat_counter #(.W(CNT_WIDTH)) u_mp_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (mp_inc),
        .count (mp_count)
    );

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: driver pushes model
// expectations, a monitor pops and compares each cycle.
module tb_fetch_pc_unit;

    localparam int CW  = 4;
    localparam int SAT = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          IF_DONE = 1'b0, MEM_DONE = 1'b0;
    logic          load_use_stall = 1'b0;
    logic          trap_req = 1'b0, mret_req = 1'b0;
    logic [31:0]   trap_vec = '0, mret_pc = '0;
    logic          IF_pTaken = 1'b0;
    logic [31:0]   IF_pTarget = '0;
    logic [1:0]    EX_bType = '0;
    logic          EX_rTaken = 1'b0;
    logic [31:0]   EX_bTarget = '0;
    logic [31:0]   IF_PC, ID_PC, EX_PC;
    logic          ID_valid, EX_valid;
    logic          flush_IFID, flush_IDEX, mispredict;
    logic [CW-1:0] br_count, mp_count;

    fetch_pc_unit #(.RESET_PC(32'h0), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .IF_DONE(IF_DONE), .MEM_DONE(MEM_DONE),
        .load_use_stall(load_use_stall),
        .trap_req(trap_req), .trap_vec(trap_vec),
        .mret_req(mret_req), .mret_pc(mret_pc),
        .IF_pTaken(IF_pTaken), .IF_pTarget(IF_pTarget),
        .EX_bType(EX_bType), .EX_rTaken(EX_rTaken),
        .EX_bTarget(EX_bTarget),
        .IF_PC(IF_PC), .ID_PC(ID_PC), .EX_PC(EX_PC),
        .ID_valid(ID_valid), .EX_valid(EX_valid),
        .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX),
        .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit        v;
        bit [31:0] pc;
        bit        pt;
        bit [31:0] ptg;
    } slot_t;

    typedef struct {
        bit [31:0] if_pc, id_pc, ex_pc;
        bit        id_v, ex_v, mp, fl;
        int        br, mpc;
    } exp_t;

    exp_t      exp_q[$];
    int        n_checks = 0;
    int        n_fail = 0;
    bit        done = 0;

    bit [31:0] m_pc;
    slot_t     m_id, m_ex;
    int        m_br, m_mp;

    bit        s_ifd, s_memd, s_stall, s_trap, s_mret, s_ipt, s_rt;
    bit [31:0] s_tv, s_mpc, s_iptg, s_btgt;
    bit [1:0]  s_bt;

    task automatic chk(string n, logic [31:0] got, logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", n, got, want, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = 32'h0;
        m_id = '{default: 0};
        m_ex = '{default: 0};
        m_br = 0;
        m_mp = 0;
    endtask

    task automatic idle();
        s_ifd = 1; s_memd = 1; s_stall = 0;
        s_trap = 0; s_tv = 0; s_mret = 0; s_mpc = 0;
        s_ipt = 0; s_iptg = 0; s_bt = 0; s_rt = 0; s_btgt = 0;
    endtask

    // Apply one cycle of stimulus and advance the reference model.
    task automatic step();
        bit [31:0] seq, actual, pred, nxt;
        bit        taken, mp, adv;
        exp_t      e;
        @(negedge clk);
        IF_DONE = s_ifd; MEM_DONE = s_memd;
        load_use_stall = s_stall;
        trap_req = s_trap; trap_vec = s_tv;
        mret_req = s_mret; mret_pc = s_mpc;
        IF_pTaken = s_ipt; IF_pTarget = s_iptg;
        EX_bType = s_bt; EX_rTaken = s_rt; EX_bTarget = s_btgt;

        seq    = m_ex.pc + 32'd4;
        taken  = (s_bt != 2'd0) && (s_bt != 2'd2 || s_rt);
        actual = taken ? s_btgt : seq;
        pred   = m_ex.pt ? m_ex.ptg : seq;
        mp     = m_ex.v && (actual != pred);
        adv    = s_ifd && s_memd;

        e.if_pc = m_pc; e.id_pc = m_id.pc; e.ex_pc = m_ex.pc;
        e.id_v = m_id.v; e.ex_v = m_ex.v;
        e.mp = mp; e.fl = s_trap || s_mret || mp;
        e.br = m_br; e.mpc = m_mp;
        exp_q.push_back(e);

        if (adv) begin
            if (m_ex.v && s_bt != 2'd0) m_br = (m_br < SAT) ? m_br + 1 : SAT;
            if (mp) m_mp = (m_mp < SAT) ? m_mp + 1 : SAT;
            if (s_trap || s_mret || mp) begin
                m_pc = s_trap ? s_tv : (s_mret ? s_mpc : actual);
                m_id.v = 0;
                m_ex.v = 0;
            end else if (s_stall) begin
                m_ex.v = 0;
            end else begin
                nxt  = m_pc + 32'd4;
                m_ex = m_id;
                m_id = '{v: 1, pc: m_pc, pt: s_ipt, ptg: s_iptg};
                m_pc = s_ipt ? s_iptg : nxt;
            end
        end
    endtask

    task automatic rand_step();
        s_ifd   = ($urandom_range(0, 99) < 85);
        s_memd  = ($urandom_range(0, 99) < 92);
        s_stall = ($urandom_range(0, 99) < 15);
        s_trap  = ($urandom_range(0, 99) < 4);
        s_tv    = $urandom & 32'h0000_03FC;
        s_mret  = ($urandom_range(0, 99) < 4);
        s_mpc   = $urandom & 32'h0000_0FFC;
        s_ipt   = ($urandom_range(0, 99) < 30);
        s_iptg  = $urandom & 32'h0000_03FC;
        s_bt    = 2'($urandom);
        s_rt    = 1'($urandom);
        if ($urandom_range(0, 1) == 1) begin
            s_rt   = 1;
            s_btgt = m_ex.ptg;
            if (s_bt == 2'd0) s_bt = 2'd2;
        end else begin
            s_btgt = $urandom & 32'h0000_03FC;
        end
        step();
    endtask

    task automatic mid_reset();
        #3;
        IF_DONE = 0; MEM_DONE = 0;
        trap_req = 0; mret_req = 0;
        rst = 1;
        #1;
        chk("rst_if_pc", IF_PC, 32'h0);
        chk("rst_id_v", {31'b0, ID_valid}, 32'h0);
        chk("rst_ex_v", {31'b0, EX_valid}, 32'h0);
        chk("rst_id_pc", ID_PC, 32'h0);
        chk("rst_ex_pc", EX_PC, 32'h0);
        chk("rst_mp", {31'b0, mispredict}, 32'h0);
        chk("rst_fl", {30'b0, flush_IFID, flush_IDEX}, 32'h0);
        chk("rst_br", {28'b0, br_count}, 32'h0);
        chk("rst_mpc", {28'b0, mp_count}, 32'h0);
        model_reset();
        #0.5 rst = 0;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("if_pc", IF_PC, e.if_pc);
                chk("id_valid", {31'b0, ID_valid}, {31'b0, e.id_v});
                chk("ex_valid", {31'b0, EX_valid}, {31'b0, e.ex_v});
                if (e.id_v) chk("id_pc", ID_PC, e.id_pc);
                if (e.ex_v) chk("ex_pc", EX_PC, e.ex_pc);
                chk("mispredict", {31'b0, mispredict}, {31'b0, e.mp});
                chk("flush_ifid", {31'b0, flush_IFID}, {31'b0, e.fl});
                chk("flush_idex", {31'b0, flush_IDEX}, {31'b0, e.fl});
                chk("br_count", {28'b0, br_count}, e.br);
                chk("mp_count", {28'b0, mp_count}, e.mpc);
            end
        end
    end

    initial begin : driver
        model_reset();
        idle();
        #13 rst = 0;

        // sequential fetch from reset
        repeat (4) step();
        // predicted-taken at 0x10, resolved correctly in EX
        idle(); s_ipt = 1; s_iptg = 32'h40; step();
        idle(); step();
        idle(); s_bt = 2; s_rt = 1; s_btgt = 32'h40; step();
        // mispredict: predicted taken, resolves not-taken
        idle(); s_trap = 1; s_tv = 32'h10; step();
        idle(); s_ipt = 1; s_iptg = 32'h40; step();
        idle(); step();
        idle(); s_bt = 2; s_rt = 0; s_btgt = 32'h40; step();
        // load-use stall at 0x20
        idle(); repeat (3) step();
        idle(); s_stall = 1; step();
        idle(); repeat (2) step();
        // trap together with a mispredict
        idle(); s_ipt = 1; s_iptg = 32'h80; step();
        idle(); step();
        idle(); s_bt = 0; s_trap = 1; s_tv = 32'h100; step();
        // IF_DONE low holds all state
        idle(); s_ifd = 0; s_ipt = 1; s_iptg = 32'h200; repeat (3) step();
        idle(); repeat (2) step();
        // PC wrap-around
        idle(); s_trap = 1; s_tv = 32'hFFFF_FFFC; step();
        idle(); repeat (3) step();

        repeat (250) rand_step();
        mid_reset();
        idle(); repeat (3) step();
        repeat (250) rand_step();

        @(negedge clk);
        #4;
        chk("scoreboard_drained", exp_q.size(), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
